dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  SHALL be the access requests from requester 0 and requester 1.
REQ-006 we0 / we1  input  1  SHALL select write (1) or read (0) for the corresponding request.
REQ-007 addr0 / addr1  input  ADDR_WIDTH  SHALL be the request word addresses.
REQ-008 wdata0 / wdata1  input  DATA_WIDTH  SHALL be the request write data.
REQ-009 gnt0 / gnt1  output  1  SHALL be the per-requester grants; a transfer occurs when reqK and gntK are both high at a clock edge.
REQ-010 done0 / done1  output  1  SHALL pulse for one cycle when the granted access completes.
REQ-011 rdata  output  DATA_WIDTH  SHALL be the shared read-return bus, valid while done0 or done1 is high.
REQ-012 mem_addr  output  ADDR_WIDTH  SHALL drive the memory address for both read and write.
REQ-013 mem_wdata  output  DATA_WIDTH  SHALL drive the memory write data.
REQ-014 mem_we  output  1  SHALL drive the memory write enable, active-high.
REQ-015 mem_rdata  input  DATA_WIDTH  SHALL be the combinational read data returned by the memory for mem_addr.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-017 grant_count  output  16  SHALL count total grants issued.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-019 gnt0/gnt1 SHALL be combinational, asserted only in IDLE or RESP, and at most one SHALL be high in any cycle.
REQ-020 Arbitration SHALL be as follows: with one req high, that requester wins; with both high, the requester other than last_grant wins (round-robin).
REQ-021 On a grant, the FSM SHALL capture the winner's we, addr, wdata and id into internal registers, update last_grant, and go to ACCESS at the next edge.
REQ-022 In IDLE or RESP with no req, the FSM SHALL go to (or remain in) IDLE.
REQ-023 In ACCESS, mem_addr and mem_wdata SHALL equal the captured values, and mem_we SHALL equal the captured we; in all other states mem_we SHALL be 0.
REQ-024 In ACCESS, a read SHALL capture mem_rdata into the rdata register at the end of the cycle; the FSM SHALL then go to RESP unconditionally.
REQ-025 In RESP, done of the captured id SHALL be high for exactly that cycle; rdata SHALL hold the read value for reads and 0 for writes.
REQ-026 Latency SHALL be fixed: for a grant in cycle N, the memory access occurs in N+1 and done is high in N+2.
REQ-027 Throughput SHALL be one access per 2 cycles, because a new grant is allowed in the RESP cycle.
REQ-028 Outside RESP, done0/done1 SHALL be 0 and rdata SHALL hold its last value.
REQ-029 In non-ACCESS cycles, mem_addr and mem_wdata SHALL hold their last captured values.
REQ-030 grant_count SHALL increment by 1 on each grant and wrap from 16'hFFFF to 0.
REQ-031 A requester that holds req high SHALL wait at most one competing access before being granted.
REQ-032 Changes to req, we, addr or wdata after the grant edge SHALL NOT affect the in-flight access.

Reset
REQ-033 While reset is high, the state SHALL be IDLE, last_grant 1, grant_count 0, rdata 0, and the captured registers 0.
REQ-034 While reset is high, all outputs SHALL be 0, including mem_we, which clears immediately without waiting for clk.
REQ-035 Reset asserted mid-operation SHALL abort the in-flight access with no done pulse and no memory write at any later edge.
REQ-036 After reset deasserts, requester 0 SHALL win the first tie.

Verification
REQ-037 Reset, then req0 read addr 5 with mem_rdata=32'hDEAD_BEEF at addr 5 -> gnt0 in cycle 0, mem_addr=5 with mem_we=0 in cycle 1, done0=1 with rdata=32'hDEAD_BEEF in cycle 2.
REQ-038 req0 and req1 held high from reset release, both writes -> grants alternate 0,1,0,1 in cycles 0,2,4,6; mem_we high in cycles 1,3,5,7; grant_count=4 after cycle 6.
REQ-039 req1 write addr 3 data 32'h1234 -> mem_we=1, mem_addr=3, mem_wdata=32'h1234 for exactly one cycle; done1=1 with rdata=0 the next cycle.
REQ-040 Reset asserted during an ACCESS cycle of a write -> mem_we falls before the next edge, no done pulse, busy=0.
REQ-041 Preload grant_count to 16'hFFFF via 65535 single-requester grants, then one more grant -> grant_count=0.
REQ-042 req0 drops in the RESP cycle with req1 high -> gnt1 in that RESP cycle, then back-to-back ACCESS with no idle cycle.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// combinational read path. Each grant runs a fixed three-phase sequence:
// grant (IDLE/RESP) -> memory access (ACCESS) -> done pulse (RESP).
//
// Handshake: a transfer occurs on a rising clk edge where reqK and gntK are
// both high. The winner's we/addr/wdata are captured at that edge, so later
// changes to the request inputs cannot disturb the access in flight.
// doneK then pulses exactly two cycles after the grant cycle. While doneK
// is high, rdata carries the read data, or 0 for a write.
module dm_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [15:0]           grant_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    we_q;
    logic                    id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [15:0]             grant_count_q;

    logic                    can_grant;
    logic                    win1;
    logic                    grant;

    // Arbitration and next-state: grants only outside ACCESS; on a tie the
    // requester that did not win last time is chosen.
    always_comb begin
        state_d   = state_q;
        can_grant = 1'b0;
        win1      = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        grant     = 1'b0;

        can_grant = (state_q != ACCESS) && !reset;
        win1      = req1 && (!req0 || !last_grant_q);
        gnt1      = can_grant && win1;
        gnt0      = can_grant && req0 && !win1;
        grant     = gnt0 || gnt1;

        case (state_q)
            IDLE:    state_d = grant ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = grant ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset forces IDLE, which also drops mem_we at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request and remember who won for round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            id_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant) begin
            last_grant_q <= gnt1;
            id_q         <= gnt1;
            we_q         <= gnt1 ? we1 : we0;
            addr_q       <= gnt1 ? addr1 : addr0;
            wdata_q      <= gnt1 ? wdata1 : wdata0;
        end
    end

    // Response data: read value at the end of ACCESS, or 0 for a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            rdata_q <= we_q ? '0 : mem_rdata;
        end
    end

    // Total grants issued, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count_q <= '0;
        end else if (grant) begin
            grant_count_q <= grant_count_q + 16'd1;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        mem_we      = (state_q == ACCESS) && we_q;
        done0       = (state_q == RESP) && !id_q;
        done1       = (state_q == RESP) && id_q;
        rdata       = rdata_q;
        busy        = (state_q != IDLE);
        grant_count = grant_count_q;
    end

endmodule
